mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-stage controller and MEM/WB pipeline register that consumes the EX/MEM register outputs. For ALU instructions it forwards the result into MEM/WB in one cycle. For loads and stores it runs a request/response handshake with data memory, stalls the upstream pipeline until the access completes, and then captures aligned, sign- or zero-extended writeback data. It sits between the EX/MEM register and the register-file write port.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock; all state on posedge
- rst  in  1  synchronous, active-high reset
- valid  in  1  EX/MEM slot holds a real instruction (0 = bubble)
- aluresult  in  32  ALU result; also the memory address for loads and stores
- storedata  in  32  rs2 value for stores
- rd  in  5  destination register
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W
- MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control from EX/MEM
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {aluresult[31:2], 2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0 for loads)
- dmem_ready  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- stall  out  1  combinational; upstream must hold EX/MEM when high
- wbdata  out  32  MEM/WB writeback value
- rdout  out  5  MEM/WB rd
- RegWriteout  out  1  MEM/WB write enable
- wbvalid  out  1  MEM/WB holds a completed instruction
- misalign  out  1  MEM/WB instruction had a misaligned access

## Operation
- FSM states: IDLE, REQ, RESP.
- memop = valid & (MemRead | MemWrite).
- Misaligned means: H/HU with addr[0] = 1; W with addr[1:0] ≠ 0.
- IDLE, no memop, or memop but misaligned:
  - stall = 0; MEM/WB captures the instruction at the next edge.
  - A misaligned memop issues no request and captures misalign = 1, RegWriteout = 0.
- IDLE, aligned memop:
  - stall = 1; go to REQ.
  - MEM/WB captures a bubble: wbvalid = 0, RegWriteout = 0, misalign = 0.
- REQ:
  - dmem_req = 1; dmem_we = MemWrite; addr, wdata, wstrb are driven combinationally from the held inputs.
  - ready & store: stall = 0, MEM/WB captures, go to IDLE.
  - ready & load: stall = 1, go to RESP.
  - No ready: stay in REQ, stall = 1.
- RESP:
  - dmem_req = 0; stall = !dmem_rvalid.
  - On rvalid: MEM/WB captures the extended data, go to IDLE.
- dmem_rvalid is ignored outside RESP.
- Store encoding:
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{storedata[7:0]}}.
  - SH: wstrb = 0011 << {addr[1],1'b0}, wdata = {2{storedata[15:0]}}.
  - SW: wstrb = 1111, wdata = storedata.
- Load extraction:
  - Byte lane = addr[1:0], half lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
- wbdata = MemtoReg ? loaddata : aluresult.
- RegWriteout = valid & RegWrite & !MemWrite & !misaligned.
- wbvalid = valid on any capture other than a bubble.

## Timing
- Reset values: state IDLE; wbdata = 0, rdout = 0, RegWriteout = 0, wbvalid = 0, misalign = 0; dmem_req = 0, stall = 0 in the cycle after reset.
- Reset mid-transaction: returns to IDLE at the edge and drops dmem_req. A late rvalid is ignored. MEM/WB is cleared.
- ALU instruction: MEM/WB is updated 1 edge after it appears at the inputs.
- Store, best case (ready in first REQ cycle): stall high for 1 cycle; MEM/WB updated 2 edges after arrival.
- Load, best case (ready in REQ, rvalid the cycle after): stall high for 2 cycles; MEM/WB updated 3 edges after arrival.
- The memory never asserts rvalid in the same cycle as ready for that request.
- Inputs must stay stable while stall = 1. Behaviour is undefined if they change.
- Back-to-back memory ops: the second op is evaluated in IDLE in the cycle after the first completes. There is no pipelining of requests.

## Test plan
- ALU op: aluresult = 0x1234_5678, rd = 5, RegWrite = 1 → next edge wbdata = 0x12345678, rdout = 5, RegWriteout = 1, wbvalid = 1, stall stays 0.
- LW at 0x100, ready immediate, rvalid with rdata = 0xDEADBEEF two cycles after arrival:
  - stall = 1,1,0.
  - wbdata = 0xDEADBEEF after the 3rd edge.
  - The preceding MEM/WB cycles are bubbles.
- SB at 0x103, storedata = 0x0000_00AB, ready held off 2 cycles:
  - dmem_wstrb = 1000, dmem_wdata = 0xABABABAB, dmem_addr = 0x100.
  - dmem_req high for 3 cycles; RegWriteout = 0 on capture.
- LB / LBU at 0x101, rdata = 0x0000_80FF → wbdata = 0xFFFFFF80 / 0x00000080. LH at 0x102, rdata = 0x8001_0000 → 0xFFFF8001.
- Misaligned LW at 0x102: no dmem_req, stall = 0, next edge misalign = 1, wbvalid = 1, RegWriteout = 0.
- rst asserted while in RESP, then rvalid arrives: all outputs 0 and state is IDLE; the rvalid causes no capture.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-stage controller and MEM/WB pipeline register. ALU results pass straight through;
// loads and stores run a req/ready/rvalid handshake with data memory and stall upstream until done.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] aluresult,
    input  logic [31:0] storedata,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] wbdata,
    output logic [4:0]  rdout,
    output logic        RegWriteout,
    output logic        wbvalid,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] wbdata_q;
    logic [4:0]  rd_q;
    logic        regwrite_q, wbvalid_q, misalign_q;

    logic        memop, isByte, isHalf, isWord, misaligned, capture;
    logic [3:0]  storeStrb;
    logic [31:0] storeWord, loadData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Unlisted funct3 codes behave as a full word access.
    assign memop      = valid & (MemRead | MemWrite);
    assign isByte     = (funct3 == 3'b000) || (funct3 == 3'b100);
    assign isHalf     = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign isWord     = !isByte && !isHalf;
    assign misaligned = memop & ((isHalf & aluresult[0]) | (isWord & (aluresult[1:0] != 2'b00)));

    always_comb begin
        storeStrb = 4'b1111;
        storeWord = storedata;
        if (isByte) begin
            storeStrb = 4'b0001 << aluresult[1:0];
            storeWord = {4{storedata[7:0]}};
        end else if (isHalf) begin
            storeStrb = 4'b0011 << {aluresult[1], 1'b0};
            storeWord = {2{storedata[15:0]}};
        end
    end

    // funct3[2] selects zero extension (BU/HU).
    assign loadByte = 8'(dmem_rdata >> {aluresult[1:0], 3'b000});
    assign loadHalf = aluresult[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        loadData = dmem_rdata;
        if (isByte) begin
            loadData = {{24{~funct3[2] & loadByte[7]}}, loadByte};
        end else if (isHalf) begin
            loadData = {{16{~funct3[2] & loadHalf[15]}}, loadHalf};
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop && !misaligned) begin
                    stall   = 1'b1;
                    state_d = REQ;
                end else begin
                    capture = 1'b1;
                end
            end
            REQ: begin
                if (dmem_ready && MemWrite) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    if (dmem_ready) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cycles that do not complete an instruction load a bubble; data and rd are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wbdata_q   <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            wbvalid_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                wbdata_q   <= MemtoReg ? loadData : aluresult;
                rd_q       <= rd;
                regwrite_q <= valid & RegWrite & ~MemWrite & ~misaligned;
                wbvalid_q  <= valid;
                misalign_q <= misaligned;
            end else begin
                regwrite_q <= 1'b0;
                wbvalid_q  <= 1'b0;
                misalign_q <= 1'b0;
            end
        end
    end

    assign dmem_req    = (state_q == REQ);
    assign dmem_we     = dmem_req & MemWrite;
    assign dmem_addr   = {aluresult[31:2], 2'b00};
    assign dmem_wdata  = storeWord;
    assign dmem_wstrb  = MemWrite ? storeStrb : 4'b0000;

    assign wbdata      = wbdata_q;
    assign rdout       = rd_q;
    assign RegWriteout = regwrite_q;
    assign wbvalid     = wbvalid_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed ops push expected MEM/WB contents,
// a monitor pops and compares whenever wbvalid is high; a small memory model answers requests.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] aluresult, storedata;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] wbdata;
    logic [4:0]  rdout;
    logic        RegWriteout, wbvalid, misalign;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regWrite;
        logic        misalign;
        logic        checkData;
    } wbExp_t;

    wbExp_t expQ[$];
    int     checks = 0;
    int     failures = 0;
    int     readyDelay = 0;
    int     rvalidDelay = 1;
    int     waitCnt = 0;
    int     rvCount = 0;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .valid(valid), .aluresult(aluresult), .storedata(storedata),
        .rd(rd), .funct3(funct3), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall(stall), .wbdata(wbdata), .rdout(rdout), .RegWriteout(RegWriteout),
        .wbvalid(wbvalid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: ready after readyDelay REQ cycles, load data rvalidDelay cycles after ready.
    initial begin
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            dmem_ready  = 1'b0;
            dmem_rvalid = 1'b0;
            if (rvCount > 0) begin
                rvCount--;
                if (rvCount == 0) dmem_rvalid = 1'b1;
            end
            if (dmem_req) begin
                if (waitCnt == readyDelay) begin
                    dmem_ready = 1'b1;
                    waitCnt    = 0;
                    if (!dmem_we) rvCount = rvalidDelay;
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // Monitor: every completed MEM/WB entry must match the oldest expectation.
    initial begin
        wbExp_t e;
        forever begin
            @(negedge clk);
            if (wbvalid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_wbvalid", 32'(wbvalid), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    if (e.checkData) checkOutput("wbdata", wbdata, e.data);
                    checkOutput("rdout", 32'(rdout), 32'(e.rd));
                    checkOutput("RegWriteout", 32'(RegWriteout), 32'(e.regWrite));
                    checkOutput("misalign", 32'(misalign), 32'(e.misalign));
                end
            end
        end
    end

    task automatic pushExp(input logic [31:0] data, input logic [4:0] r, input logic rw,
                           input logic mis, input logic chk);
        wbExp_t e;
        e.data = data; e.rd = r; e.regWrite = rw; e.misalign = mis; e.checkData = chk;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] r,
                                 input logic [2:0] f3, input logic mr, input logic mw,
                                 input logic m2r, input logic rw, input int rdyDly, input int rvDly,
                                 input logic [31:0] rword, output int stallCycles,
                                 output int reqCycles, output logic [3:0] strb,
                                 output logic [31:0] wd, output logic [31:0] addr);
        bit done = 0;
        @(posedge clk);
        #1;
        readyDelay = rdyDly; rvalidDelay = rvDly; dmem_rdata = rword;
        valid = 1'b1; aluresult = alu; storedata = sd; rd = r; funct3 = f3;
        MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
        stallCycles = 0; reqCycles = 0; strb = 4'h0; wd = 32'h0; addr = 32'h0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (dmem_req) begin
                reqCycles++;
                strb = dmem_wstrb; wd = dmem_wdata; addr = dmem_addr;
            end
            if (!stall) done = 1;
            else stallCycles++;
        end
        @(posedge clk);
        #1;
        valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    endtask

    initial begin
        int st, rq;
        logic [3:0]  strb;
        logic [31:0] wd, addr;

        rst = 1'b1; valid = 1'b0; aluresult = '0; storedata = '0; rd = '0; funct3 = '0;
        MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_wbdata", wbdata, 32'h0);
        checkOutput("reset_rdout", 32'(rdout), 32'h0);
        checkOutput("reset_RegWriteout", 32'(RegWriteout), 32'h0);
        checkOutput("reset_wbvalid", 32'(wbvalid), 32'h0);
        checkOutput("reset_misalign", 32'(misalign), 32'h0);
        checkOutput("reset_dmem_req", 32'(dmem_req), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);

        pushExp(32'h12345678, 5'd5, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h12345678, 32'h0, 5'd5, 3'b010, 0, 0, 0, 1, 0, 1, 32'h0, st, rq, strb, wd, addr);
        checkOutput("alu_stall_cycles", 32'(st), 32'd0);
        checkOutput("alu_req_cycles", 32'(rq), 32'd0);

        pushExp(32'hDEADBEEF, 5'd6, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h100, 32'h0, 5'd6, 3'b010, 1, 0, 1, 1, 0, 1, 32'hDEADBEEF, st, rq, strb, wd, addr);
        checkOutput("lw_stall_cycles", 32'(st), 32'd2);
        checkOutput("lw_req_cycles", 32'(rq), 32'd1);
        checkOutput("lw_addr", addr, 32'h100);

        pushExp(32'h103, 5'd7, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h103, 32'h000000AB, 5'd7, 3'b000, 0, 1, 0, 1, 2, 1, 32'h0, st, rq, strb, wd, addr);
        checkOutput("sb_stall_cycles", 32'(st), 32'd3);
        checkOutput("sb_req_cycles", 32'(rq), 32'd3);
        checkOutput("sb_wstrb", 32'(strb), 32'h8);
        checkOutput("sb_wdata", wd, 32'hABABABAB);
        checkOutput("sb_addr", addr, 32'h100);

        pushExp(32'h102, 5'd12, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h102, 32'h1234CAFE, 5'd12, 3'b001, 0, 1, 0, 0, 0, 1, 32'h0, st, rq, strb, wd, addr);
        checkOutput("sh_wstrb", 32'(strb), 32'hC);
        checkOutput("sh_wdata", wd, 32'hCAFECAFE);

        pushExp(32'h104, 5'd13, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'h104, 32'h89ABCDEF, 5'd13, 3'b010, 0, 1, 0, 0, 0, 1, 32'h0, st, rq, strb, wd, addr);
        checkOutput("sw_wstrb", 32'(strb), 32'hF);
        checkOutput("sw_wdata", wd, 32'h89ABCDEF);
        checkOutput("sw_addr", addr, 32'h104);

        pushExp(32'hFFFFFF80, 5'd8, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h101, 32'h0, 5'd8, 3'b000, 1, 0, 1, 1, 1, 2, 32'h000080FF, st, rq, strb, wd, addr);
        checkOutput("lb_stall_cycles", 32'(st), 32'd4);
        checkOutput("lb_wstrb", 32'(strb), 32'h0);

        pushExp(32'h00000080, 5'd9, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h101, 32'h0, 5'd9, 3'b100, 1, 0, 1, 1, 0, 1, 32'h000080FF, st, rq, strb, wd, addr);

        pushExp(32'hFFFF8001, 5'd10, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h102, 32'h0, 5'd10, 3'b001, 1, 0, 1, 1, 0, 1, 32'h80010000, st, rq, strb, wd, addr);

        pushExp(32'h00008001, 5'd11, 1'b1, 1'b0, 1'b1);
        applyStimulus(32'h102, 32'h0, 5'd11, 3'b101, 1, 0, 1, 1, 0, 1, 32'h80010000, st, rq, strb, wd, addr);

        pushExp(32'h0, 5'd14, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'h102, 32'h0, 5'd14, 3'b010, 1, 0, 1, 1, 0, 1, 32'h0, st, rq, strb, wd, addr);
        checkOutput("mis_stall_cycles", 32'(st), 32'd0);
        checkOutput("mis_req_cycles", 32'(rq), 32'd0);

        // Reset while waiting in RESP; the late rvalid must not produce a capture.
        @(posedge clk);
        #1;
        readyDelay = 0; rvalidDelay = 3; dmem_rdata = 32'h55AA55AA;
        valid = 1; aluresult = 32'h200; rd = 5'd15; funct3 = 3'b010;
        MemRead = 1; MemtoReg = 1; RegWrite = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        valid = 0; MemRead = 0; MemtoReg = 0; RegWrite = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_resp_wbdata", wbdata, 32'h0);
        checkOutput("rst_resp_rdout", 32'(rdout), 32'h0);
        checkOutput("rst_resp_wbvalid", 32'(wbvalid), 32'h0);
        checkOutput("rst_resp_dmem_req", 32'(dmem_req), 32'h0);
        checkOutput("rst_resp_stall", 32'(stall), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("late_rvalid_wbvalid", 32'(wbvalid), 32'h0);
            checkOutput("late_rvalid_RegWriteout", 32'(RegWriteout), 32'h0);
        end

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
